// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad debounce/decode block.
//   state_e    : controller states (IDLE, DEBOUNCE, PRESSED, RELEASE)
//   NO_KEY     : row/column value with no line pulled low
//   KEY_W      : width of the decoded key code
//   LINE_W     : width of the row and column buses
//   IDX_W      : width of a row or column index
package keypad_pkg;

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned LINE_W = 4;
  localparam int unsigned IDX_W  = 2;

  localparam logic [LINE_W-1:0] NO_KEY = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Larger of two parameters, used to size the shared counter width.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Key code is 4*row + col, which is simply the two indices concatenated.
  function automatic logic [KEY_W-1:0] make_key_code(input logic [IDX_W-1:0] row_idx,
                                                     input logic [IDX_W-1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage : keypad_pkg

// File: rtl/keypad_onehot_index.sv
// Active-low one-hot to index converter.
//   vec_n   : 4-bit active-low vector (exactly one bit low when valid)
//   idx_c   : position of the low bit (0 when not valid)
//   valid_c : high when exactly one bit of vec_n is low
module keypad_onehot_index
  import keypad_pkg::*;
(
  input  logic [LINE_W-1:0] vec_n,
  output logic [IDX_W-1:0]  idx_c,
  output logic              valid_c
);

  // Any pattern other than a single low bit (none, or several) is rejected.
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    case (vec_n)
      4'b1110: begin idx_c = 2'd0; valid_c = 1'b1; end
      4'b1101: begin idx_c = 2'd1; valid_c = 1'b1; end
      4'b1011: begin idx_c = 2'd2; valid_c = 1'b1; end
      4'b0111: begin idx_c = 2'd3; valid_c = 1'b1; end
      default: begin idx_c = '0;   valid_c = 1'b0; end
    endcase
  end

endmodule : keypad_onehot_index

// File: rtl/keypad_debounce_decode.sv
// Debounces a scanned 4x4 keypad and decodes the accepted key.
//   clock_Value    : system clock, rising edge
//   reset_n        : asynchronous active-low reset
//   colValue       : active-low column drive from the scanner
//   rowValue       : active-low row sense, 4'b1111 = no key
//   debounceEnable : scanner has frozen its column on a low row
//   keyCode        : last accepted key, 4*row_index + col_index
//   keyValid       : one-cycle pulse, keyCode valid in the same cycle
//   keyHeld        : high from press acceptance to release acceptance
// Optional feature: define KEYPAD_REPEAT_EN to emit auto-repeat pulses every
// REPEAT_CYCLES clocks while the key stays pressed.
module keypad_debounce_decode
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 4096
) (
  input  logic              clock_Value,
  input  logic              reset_n,
  input  logic [LINE_W-1:0] colValue,
  input  logic [LINE_W-1:0] rowValue,
  input  logic              debounceEnable,
  output logic [KEY_W-1:0]  keyCode,
  output logic              keyValid,
  output logic              keyHeld
);

  localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYCLES, REPEAT_CYCLES)) + 1;

  // Entry into DEBOUNCE/RELEASE is the first stable sample and leaves the
  // counter at 0; the counter then reaches DEBOUNCE_CYCLES-1 on the edge of
  // the final stable sample, so the decision is taken while it holds D-2.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Saturating increment so no counter can ever wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_e state_q, state_d;

  logic [LINE_W-1:0] row_snap_q, row_snap_d;
  logic [LINE_W-1:0] col_snap_q, col_snap_d;
  logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic [KEY_W-1:0]  key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
`endif

  logic [IDX_W-1:0]  row_idx_c, col_idx_c;
  logic              row_ok_c, col_ok_c;
  logic              start_c;
  logic              snap_match_c;
  logic              rows_idle_c;
  logic              db_done_c;

  // Row and column decoders.
  keypad_onehot_index u_row_index (
    .vec_n   (rowValue),
    .idx_c   (row_idx_c),
    .valid_c (row_ok_c)
  );

  keypad_onehot_index u_col_index (
    .vec_n   (colValue),
    .idx_c   (col_idx_c),
    .valid_c (col_ok_c)
  );

  // A snapshot is only ever taken of a valid pattern, so matching it implies validity.
  assign start_c      = debounceEnable && row_ok_c && col_ok_c;
  assign snap_match_c = debounceEnable && (rowValue == row_snap_q) && (colValue == col_snap_q);
  assign rows_idle_c  = (rowValue == NO_KEY);
  assign db_done_c    = (db_cnt_q == DB_LAST);

  // State register.
  always_ff @(posedge clock_Value or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_c) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!snap_match_c)  state_d = IDLE;
        else if (db_done_c) state_d = PRESSED;
      end
      PRESSED: begin
        // A different key pressed while held is ignored; only full release matters.
        if (rows_idle_c) state_d = RELEASE;
      end
      RELEASE: begin
        if (!rows_idle_c)   state_d = PRESSED;
        else if (db_done_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output, snapshot and counter next values.
  always_comb begin
    row_snap_d  = row_snap_q;
    col_snap_d  = col_snap_q;
    db_cnt_d    = db_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    // Repeat counter only runs in PRESSED and is cleared everywhere else.
    rpt_cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        db_cnt_d = '0;
        if (start_c) begin
          row_snap_d = rowValue;
          col_snap_d = colValue;
        end
      end
      DEBOUNCE: begin
        if (!snap_match_c) begin
          db_cnt_d = '0;
        end else if (db_done_c) begin
          db_cnt_d    = '0;
          key_code_d  = make_key_code(row_idx_c, col_idx_c);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q);
        end
      end
      PRESSED: begin
        db_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
        if (!rows_idle_c) begin
          if (rpt_cnt_q == RPT_LAST) begin
            rpt_cnt_d   = '0;
            key_valid_d = 1'b1;
          end else begin
            rpt_cnt_d = sat_inc(rpt_cnt_q);
          end
        end
`endif
      end
      RELEASE: begin
        if (!rows_idle_c) begin
          db_cnt_d = '0;
        end else if (db_done_c) begin
          db_cnt_d   = '0;
          key_held_d = 1'b0;
        end else begin
          db_cnt_d = sat_inc(db_cnt_q);
        end
      end
      default: begin
        db_cnt_d   = '0;
        key_held_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock_Value or negedge reset_n) begin
    if (!reset_n) begin
      row_snap_q  <= NO_KEY;
      col_snap_q  <= NO_KEY;
      db_cnt_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_snap_q  <= row_snap_d;
      col_snap_q  <= col_snap_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat counter.
  always_ff @(posedge clock_Value or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`endif

  assign keyCode  = key_code_q;
  assign keyValid = key_valid_q;
  assign keyHeld  = key_held_q;

endmodule : keypad_debounce_decode

// File: tb/tb_keypad_debounce_decode.sv
// Randomized, self-checking bench for keypad_debounce_decode with a
// run-length reference model of the debounce/release rules.
module tb_keypad_debounce_decode;

  localparam int DB  = 16;
  localparam int RPT = 32;

  logic       clock_Value;
  logic       reset_n;
  logic [3:0] colValue;
  logic [3:0] rowValue;
  logic       debounceEnable;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyHeld;

  int n_tests;
  int n_fail;
  int cyc;
  int pulses;
  int last_pulse_cyc;

  // Reference model state: run lengths instead of an explicit state machine.
  int         m_run;
  int         m_rel;
  int         m_age;
  bit         m_held;
  bit         m_valid;
  logic [3:0] m_code;
  logic [3:0] m_snap_col;
  logic [3:0] m_snap_row;

  keypad_debounce_decode #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clock_Value    (clock_Value),
    .reset_n        (reset_n),
    .colValue       (colValue),
    .rowValue       (rowValue),
    .debounceEnable (debounceEnable),
    .keyCode        (keyCode),
    .keyValid       (keyValid),
    .keyHeld        (keyHeld)
  );

  initial clock_Value = 1'b0;
  always #5 clock_Value = ~clock_Value;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit one_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  function automatic int low_index(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i] == 1'b0) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_rel = 0; m_age = 0;
    m_held = 1'b0; m_valid = 1'b0; m_code = 4'h0;
  endtask

  // One clock of the behavioural rules applied to the sampled inputs.
  task automatic model_edge(input logic en, input logic [3:0] col, input logic [3:0] row);
    bit qual;
    m_valid = 1'b0;
    qual = en && one_low(col) && one_low(row);
    if (!m_held) begin
      if (m_run == 0) begin
        if (qual) begin
          m_run = 1; m_snap_col = col; m_snap_row = row;
        end
      end else if (qual && col == m_snap_col && row == m_snap_row) begin
        m_run++;
        if (m_run == DB) begin
          m_valid = 1'b1;
          m_code  = 4'(4 * low_index(row) + low_index(col));
          m_held  = 1'b1;
          m_run = 0; m_rel = 0; m_age = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (m_rel == 0) begin
      if (row == 4'hF) begin
        m_rel = 1; m_age = 0;
      end else begin
        m_age++;
`ifdef KEYPAD_REPEAT_EN
        if (m_age == RPT) begin
          m_valid = 1'b1; m_age = 0;
        end
`endif
      end
    end else begin
      if (row != 4'hF) begin
        m_rel = 0; m_age = 0;
      end else begin
        m_rel++;
        if (m_rel == DB) begin
          m_held = 1'b0; m_rel = 0;
        end
      end
    end
  endtask

  // Drive inputs, take one clock, compare outputs 1 time unit after the edge.
  task automatic step(input logic en, input logic [3:0] col, input logic [3:0] row);
    debounceEnable = en; colValue = col; rowValue = row;
    @(posedge clock_Value);
    model_edge(en, col, row);
    cyc++;
    #1;
    if (keyValid === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
    end
    check("keyValid", 32'(keyValid), 32'(m_valid));
    check("keyHeld",  32'(keyHeld),  32'(m_held));
    check("keyCode",  32'(keyCode),  32'(m_code));
  endtask

  task automatic steps(input int n, input logic en, input logic [3:0] col, input logic [3:0] row);
    for (int i = 0; i < n; i++) step(en, col, row);
  endtask

  // Mid-cycle asynchronous reset pulse, outputs checked before any clock edge.
  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_code"},  32'(keyCode),  32'h0);
    check({tag, "_valid"}, 32'(keyValid), 32'h0);
    check({tag, "_held"},  32'(keyHeld),  32'h0);
    #1 reset_n = 1'b1;
  endtask

  int start_cyc;
  int exp_rpt;

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; pulses = 0; last_pulse_cyc = 0;
    model_reset();
    m_snap_col = 4'hF; m_snap_row = 4'hF;
    reset_n = 1'b0; debounceEnable = 1'b0; colValue = 4'b1110; rowValue = 4'hF;

    // Reset state.
    repeat (2) @(posedge clock_Value);
    #1;
    check("rst_code",  32'(keyCode),  32'h0);
    check("rst_valid", 32'(keyValid), 32'h0);
    check("rst_held",  32'(keyHeld),  32'h0);
    @(negedge clock_Value);
    reset_n = 1'b1;
    steps(3, 1'b0, 4'b1110, 4'hF);

    // Clean press: col 1, row 2 -> code 9 exactly 16 clocks after first sample.
    pulses = 0; start_cyc = cyc;
    steps(DB, 1'b1, 4'b1101, 4'b1011);
    check("press_pulses", 32'(pulses), 32'd1);
    check("press_latency", 32'(last_pulse_cyc - start_cyc), 32'(DB));
    check("press_code", 32'(keyCode), 32'h9);
    steps(4, 1'b1, 4'b1101, 4'b1011);
    check("press_held", 32'(keyHeld), 32'd1);
    check("press_single", 32'(pulses), 32'd1);
    steps(DB, 1'b0, 4'b1110, 4'hF);
    check("release_held", 32'(keyHeld), 32'd0);

    // Row bounce at clock 8 aborts; a fresh 16-clock window gives one pulse.
    pulses = 0;
    steps(7, 1'b1, 4'b0111, 4'b1110);
    step(1'b1, 4'b0111, 4'hF);
    check("bounce_nopulse", 32'(pulses), 32'd0);
    steps(DB, 1'b1, 4'b0111, 4'b1110);
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_code", 32'(keyCode), 32'h3);

    // Release glitch keeps the key held with no second pulse.
    steps(5, 1'b0, 4'b0111, 4'hF);
    steps(3, 1'b1, 4'b0111, 4'b1110);
    check("glitch_held", 32'(keyHeld), 32'd1);
    check("glitch_pulses", 32'(pulses), 32'd1);
    steps(DB, 1'b0, 4'b0111, 4'hF);
    check("glitch_release", 32'(keyHeld), 32'd0);

    // Two row bits low never qualifies.
    pulses = 0;
    steps(2 * DB, 1'b1, 4'b1101, 4'b1001);
    check("multi_nopulse", 32'(pulses), 32'd0);
    check("multi_held", 32'(keyHeld), 32'd0);

    // Reset at debounce count 10, then the still-pressed key is re-debounced.
    steps(11, 1'b1, 4'b1011, 4'b1101);
    async_reset("rst_db");
    pulses = 0; start_cyc = cyc;
    steps(DB, 1'b1, 4'b1011, 4'b1101);
    check("rst_db_pulses", 32'(pulses), 32'd1);
    check("rst_db_latency", 32'(last_pulse_cyc - start_cyc), 32'(DB));
    check("rst_db_code", 32'(keyCode), 32'h6);

    // Reset while held.
    steps(5, 1'b1, 4'b1011, 4'b1101);
    async_reset("rst_held");
    steps(2, 1'b0, 4'b1110, 4'hF);

    // Long hold: auto-repeat pulses only when the feature is built in.
    steps(DB, 1'b1, 4'b1110, 4'b0111);
    check("hold_code", 32'(keyCode), 32'hC);
    pulses = 0;
    steps(100, 1'b1, 4'b1110, 4'b0111);
`ifdef KEYPAD_REPEAT_EN
    exp_rpt = 3;
`else
    exp_rpt = 0;
`endif
    check("hold_repeats", 32'(pulses), 32'(exp_rpt));
    check("hold_code_kept", 32'(keyCode), 32'hC);
    steps(DB + 2, 1'b0, 4'b1110, 4'hF);

    // Randomized segments of stable, idle and garbage patterns.
    for (int s = 0; s < 160; s++) begin
      int          kind;
      int          len;
      logic        en;
      logic [3:0]  col;
      logic [3:0]  row;
      logic [3:0]  one;
      one  = 4'b0001;
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(1, 40));
      if (kind < 6) begin
        col = ~(one << $urandom_range(0, 3));
        row = ~(one << $urandom_range(0, 3));
        en  = ($urandom_range(0, 9) != 0);
      end else if (kind < 8) begin
        col = ~(one << $urandom_range(0, 3));
        row = 4'hF;
        en  = 1'b0;
      end else begin
        col = 4'($urandom);
        row = 4'($urandom);
        en  = 1'($urandom);
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 29) == 0) step(en, col, 4'hF);
        else                            step(en, col, row);
      end
      if ($urandom_range(0, 39) == 0) async_reset("rst_rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_keypad_debounce_decode
